tone_arbiter: RTL
=================

Name: tone_arbiter

Overview:
- Shares the single square-wave tone generator between two sources: live piano keys and the song sequencer.
- Chooses the active source and drives the half-period divisor (tone_div) to the generator.
- Paces the song sequencer by issuing advance pulses, synchronised to the beat tick.
- Sits between the keypad, the song ROM/sequencer and the beep divider; all logic runs in the 5 MHz domain.

Parameters:
- KEYS, 8, number of piano keys; fixed table below covers 8.
- DIV_W, 16, width of divisor values.
- HOLD_BEATS, 2, silent beats after last key release before song playback resumes (0..15).

Ports:
- clk_5MHz  in  1  system clock, 5 MHz.
- rst_n  in  1  asynchronous active-low reset.
- beat_tick  in  1  one-cycle pulse at beat rate (4 Hz), synchronous to clk_5MHz.
- key_n  in  KEYS  active-low keys, already synchronised and debounced.
- song_en  in  1  level; enables song playback.
- song_div  in  DIV_W  divisor of current song note; 0 = rest.
- song_adv  out  1  one-cycle pulse: sequencer steps to next note.
- tone_div  out  DIV_W  divisor to tone generator; 0 = silence.
- tone_load  out  1  one-cycle pulse when tone_div takes a new value.
- src  out  2  00 idle, 01 key, 10 song, 11 hold.

Behaviour:
- Reset (async, rst_n=0): state IDLE, tone_div=0, tone_load=0, song_adv=0, src=00, hold_cnt=0. Release takes effect on the next clk_5MHz edge.
- All outputs are registered. Latency from an input change to an output change is 1 cycle.
- Key table (key index -> divisor): 0:11466, 1:10216, 2:9101, 3:8590, 4:7653, 5:6818, 6:6072, 7:5733.
- Key priority: lowest-index pressed key wins; other pressed keys are ignored.
- Any pressed key means any key_n bit = 0.

State machine (src encodes state):
- IDLE:
  - Any key pressed -> KEY.
  - Else song_en=1 -> SONG.
  - tone_div=0.
- KEY:
  - tone_div = table[winning key]; re-evaluated every cycle, so a change of winner updates tone_div.
  - All keys released -> HOLD with hold_cnt=0 and tone_div=0.
  - song_adv is never asserted in KEY; beat_tick is ignored.
- HOLD:
  - tone_div=0.
  - Each beat_tick increments hold_cnt.
  - Any key pressed -> KEY; this has priority over expiry.
  - When hold_cnt==HOLD_BEATS: -> SONG if song_en=1, else IDLE.
  - HOLD_BEATS=0: leave HOLD the cycle after entry.
- SONG:
  - tone_div = song_div, registered each cycle.
  - beat_tick with no key pressed -> song_adv=1 the next cycle.
  - Any key pressed -> KEY (key wins over a simultaneous beat_tick; no song_adv).
  - song_en=0 -> IDLE, tone_div=0. Key press takes priority over song_en=0.

Output rules:
- tone_load=1 exactly in the cycle tone_div differs from its previous value, including changes to 0. A constant tone_div gives no pulse.
- song_adv is never asserted two cycles in a row.
- song_adv is never asserted outside SONG.
- hold_cnt is 4 bits and saturates at 15; it is never compared beyond HOLD_BEATS.
- Song position is owned by the sequencer; the arbiter never rewinds it. The song resumes at the note after the last advanced one.
- Reset asserted mid-note: outputs clear immediately. The sequencer is not reset by this block.

Test Plan:
- Reset, then release with keys idle and song_en=0 -> src=00, tone_div=0, no tone_load, no song_adv over 1000 cycles.
- song_en=1, song_div=11466, beat_tick every 100 cycles -> src=10, tone_div=11466 after 1 cycle, single tone_load, song_adv one cycle after each tick.
- In SONG, press key_n[2] on the same cycle as beat_tick -> src=01, tone_div=9101, tone_load pulse, no song_adv.
- Hold keys 5 and 1 together, then release 1 -> tone_div=10216, then 6818, each with one tone_load.
- Release all keys with HOLD_BEATS=2, song_en=1 -> tone_div=0 and src=11 until the 2nd beat_tick, then src=10 and tone_div=song_div. A key press during HOLD returns to KEY.
- Drop rst_n mid-note in KEY and in SONG -> all outputs 0 asynchronously. After release, the sequence restarts from IDLE.

Source files
------------

// File: rtl/tone_arbiter.sv
// Arbitrates the shared square-wave tone generator between live piano keys and
// the song sequencer, and paces the sequencer with beat-synchronised advance pulses.
module tone_arbiter #(
  parameter int KEYS       = 8,
  parameter int DIV_W      = 16,
  parameter int HOLD_BEATS = 2
) (
  input  logic             clk_5MHz,
  input  logic             rst_n,
  input  logic             beat_tick,
  input  logic [KEYS-1:0]  key_n,
  input  logic             song_en,
  input  logic [DIV_W-1:0] song_div,
  output logic             song_adv,
  output logic [DIV_W-1:0] tone_div,
  output logic             tone_load,
  output logic [1:0]       src
);

  localparam int         IDX_W    = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_BEATS);

  // The state encoding doubles as the src output code.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_KEY  = 2'b01,
    ST_SONG = 2'b10,
    ST_HOLD = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_hold_cnt;
  logic [3:0]       w_hold_cnt_nxt;
  logic [DIV_W-1:0] r_tone_div;
  logic [DIV_W-1:0] w_tone_div_nxt;
  logic             r_tone_load;
  logic             r_song_adv;
  logic             w_song_adv_nxt;
  logic             w_any_key;
  logic [IDX_W-1:0] w_win_idx;
  logic [DIV_W-1:0] w_key_div;

  assign w_any_key = ~&key_n;

  // Scan from the top down so the lowest-index pressed key is the last writer.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_win_idx = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (!key_n[i]) w_win_idx = i[IDX_W-1:0];
    end
  end

  always_comb begin
    w_key_div = '0;
    case (w_win_idx)
      IDX_W'(0): w_key_div = DIV_W'(11466);
      IDX_W'(1): w_key_div = DIV_W'(10216);
      IDX_W'(2): w_key_div = DIV_W'(9101);
      IDX_W'(3): w_key_div = DIV_W'(8590);
      IDX_W'(4): w_key_div = DIV_W'(7653);
      IDX_W'(5): w_key_div = DIV_W'(6818);
      IDX_W'(6): w_key_div = DIV_W'(6072);
      IDX_W'(7): w_key_div = DIV_W'(5733);
      default:   w_key_div = '0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any_key)    w_state_nxt = ST_KEY;
        else if (song_en) w_state_nxt = ST_SONG;
      end
      ST_KEY: begin
        if (!w_any_key) begin
          w_state_nxt    = ST_HOLD;
          w_hold_cnt_nxt = '0;
        end
      end
      ST_HOLD: begin
        // A key press beats expiry; expiry beats counting a tick.
        if (w_any_key) begin
          w_state_nxt = ST_KEY;
        end else if (r_hold_cnt == HOLD_LIM) begin
          w_state_nxt = song_en ? ST_SONG : ST_IDLE;
        end else if (beat_tick && (r_hold_cnt != 4'hF)) begin
          w_hold_cnt_nxt = r_hold_cnt + 4'd1;
        end
      end
      ST_SONG: begin
        if (w_any_key)     w_state_nxt = ST_KEY;
        else if (!song_en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The divisor follows the state being entered so src and tone_div change together.
  always_comb begin
    w_tone_div_nxt = '0;
    case (w_state_nxt)
      ST_KEY:  w_tone_div_nxt = w_key_div;
      ST_SONG: w_tone_div_nxt = song_div;
      default: w_tone_div_nxt = '0;
    endcase
  end

  // Advance only while staying in SONG, and never on two consecutive cycles.
  assign w_song_adv_nxt = (r_state == ST_SONG) && beat_tick && !w_any_key &&
                          song_en && !r_song_adv;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_5MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold_cnt  <= '0;
      r_tone_div  <= '0;
      r_tone_load <= 1'b0;
      r_song_adv  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_tone_div  <= w_tone_div_nxt;
      r_tone_load <= (w_tone_div_nxt != r_tone_div);
      r_song_adv  <= w_song_adv_nxt;
    end
  end

  assign src       = r_state;
  assign tone_div  = r_tone_div;
  assign tone_load = r_tone_load;
  assign song_adv  = r_song_adv;

endmodule
